// File: rtl/network_msg_queue_pkg.sv
// Shared widths, message layout and sizing helpers for the network message queue.
package network_msg_queue_pkg;

  localparam int unsigned NMQ_ID_W   = 2;
  localparam int unsigned NMQ_ADDR_W = 26;
  localparam int unsigned NMQ_TYPE_W = 2;

  typedef struct packed {
    logic [NMQ_ID_W-1:0] src;
    logic [NMQ_ID_W-1:0] dst;
  } nmq_header_t;

  typedef struct packed {
    logic [NMQ_ADDR_W-1:0] addr_block;
    logic [NMQ_TYPE_W-1:0] p_type;
  } nmq_payload_t;

  typedef struct packed {
    nmq_header_t  header;
    nmq_payload_t payload;
  } nmq_msg_t;

  localparam int unsigned NMQ_MSG_W = $bits(nmq_msg_t);

  // A single-entry queue still needs a one-bit pointer to index storage.
  function automatic int unsigned nmq_ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/queue_wrap_ptr.sv
// Modulo-DEPTH pointer: advances on inc, wraps DEPTH-1 -> 0, async active-high reset.
module queue_wrap_ptr
  import network_msg_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PTR_W = nmq_ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/network_msg_queue.sv
// Circular-buffer message queue with optional pipe (enq while full) and flow (empty bypass) modes.
module network_msg_queue
  import network_msg_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ID_W   = NMQ_ID_W,
  parameter int unsigned ADDR_W = NMQ_ADDR_W,
  parameter int unsigned TYPE_W = NMQ_TYPE_W,
  parameter bit          PIPE   = 1'b0,
  parameter bit          FLOW   = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         io_enq_ready,
  input  logic                         io_enq_valid,
  input  logic [ID_W-1:0]              io_enq_bits_header_src,
  input  logic [ID_W-1:0]              io_enq_bits_header_dst,
  input  logic [ADDR_W-1:0]            io_enq_bits_payload_addr_block,
  input  logic [TYPE_W-1:0]            io_enq_bits_payload_p_type,
  input  logic                         io_deq_ready,
  output logic                         io_deq_valid,
  output logic [ID_W-1:0]              io_deq_bits_header_src,
  output logic [ID_W-1:0]              io_deq_bits_header_dst,
  output logic [ADDR_W-1:0]            io_deq_bits_payload_addr_block,
  output logic [TYPE_W-1:0]            io_deq_bits_payload_p_type,
  output logic [$clog2(DEPTH+1)-1:0]   io_count
);

  localparam int unsigned MSG_W = 2 * ID_W + ADDR_W + TYPE_W;
  localparam int unsigned PTR_W = nmq_ptr_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] enq_ptr;
  logic [PTR_W-1:0] deq_ptr;
  logic             maybe_full;
  logic             ptr_match;
  logic             empty;
  logic             full;
  logic             do_enq;
  logic             do_deq;
  logic             bypass;
  logic             wr_en;
  logic             rd_en;
  logic [MSG_W-1:0] wdata;
  logic [MSG_W-1:0] head;
  logic [MSG_W-1:0] mem [DEPTH];

  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;

  assign io_enq_ready = PIPE ? (~full | io_deq_ready) : ~full;
  assign io_deq_valid = (FLOW && empty) ? io_enq_valid : ~empty;

  assign do_enq = io_enq_ready & io_enq_valid;
  assign do_deq = io_deq_ready & io_deq_valid;

  // A message passed straight through on an empty queue never touches storage.
  assign bypass = FLOW & empty & io_deq_ready;
  assign wr_en  = do_enq & ~bypass;
  assign rd_en  = do_deq & ~bypass;

  assign wdata = {io_enq_bits_header_src, io_enq_bits_header_dst,
                  io_enq_bits_payload_addr_block, io_enq_bits_payload_p_type};

  queue_wrap_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_enq_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_en),
    .ptr   (enq_ptr)
  );

  queue_wrap_ptr #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_deq_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_en),
    .ptr   (deq_ptr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      maybe_full <= 1'b0;
    end else if (wr_en != rd_en) begin
      maybe_full <= wr_en;
    end
  end

  // Storage is deliberately unreset; occupancy state alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[enq_ptr] <= wdata;
    end
  end

  assign head = (FLOW && empty) ? wdata : mem[deq_ptr];

  assign {io_deq_bits_header_src, io_deq_bits_header_dst,
          io_deq_bits_payload_addr_block, io_deq_bits_payload_p_type} = head;

  // Occupancy from the pointer distance, widened before subtracting so nothing wraps.
  always_comb begin
    io_count = '0;
    if (full) begin
      io_count = CNT_W'(DEPTH);
    end else if (enq_ptr >= deq_ptr) begin
      io_count = CNT_W'(enq_ptr) - CNT_W'(deq_ptr);
    end else begin
      io_count = CNT_W'(DEPTH) - CNT_W'(deq_ptr) + CNT_W'(enq_ptr);
    end
  end

endmodule

// File: tb/tb_network_msg_queue.sv
// Directed bench for network_msg_queue across depth, pipe and flow configurations.
module tb_network_msg_queue;
  import network_msg_queue_pkg::*;

  localparam int unsigned NQ = 5;
  localparam int unsigned Q4 = 0;  // DEPTH=4
  localparam int unsigned Q3 = 1;  // DEPTH=3
  localparam int unsigned QP = 2;  // DEPTH=2, PIPE
  localparam int unsigned QF = 3;  // DEPTH=2, FLOW
  localparam int unsigned Q1 = 4;  // DEPTH=1

  logic        clk = 1'b0;
  logic        reset;
  logic        enq_valid [NQ];
  logic        enq_ready [NQ];
  logic        deq_valid [NQ];
  logic        deq_ready [NQ];
  nmq_msg_t    enq_msg   [NQ];
  logic [1:0]  d_src     [NQ];
  logic [1:0]  d_dst     [NQ];
  logic [25:0] d_addr    [NQ];
  logic [1:0]  d_typ     [NQ];
  logic [31:0] cnt       [NQ];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NQ; gi++) begin : g_dut
    localparam int unsigned D  = (gi == 0) ? 4 : (gi == 1) ? 3 : (gi == 4) ? 1 : 2;
    localparam int unsigned CW = $clog2(D + 1);
    logic [CW-1:0] count;

    network_msg_queue #(
      .DEPTH  (D),
      .ID_W   (2),
      .ADDR_W (26),
      .TYPE_W (2),
      .PIPE   (gi == 2),
      .FLOW   (gi == 3)
    ) u_dut (
      .clk                            (clk),
      .reset                          (reset),
      .io_enq_ready                   (enq_ready[gi]),
      .io_enq_valid                   (enq_valid[gi]),
      .io_enq_bits_header_src         (enq_msg[gi].header.src),
      .io_enq_bits_header_dst         (enq_msg[gi].header.dst),
      .io_enq_bits_payload_addr_block (enq_msg[gi].payload.addr_block),
      .io_enq_bits_payload_p_type     (enq_msg[gi].payload.p_type),
      .io_deq_ready                   (deq_ready[gi]),
      .io_deq_valid                   (deq_valid[gi]),
      .io_deq_bits_header_src         (d_src[gi]),
      .io_deq_bits_header_dst         (d_dst[gi]),
      .io_deq_bits_payload_addr_block (d_addr[gi]),
      .io_deq_bits_payload_p_type     (d_typ[gi]),
      .io_count                       (count)
    );

    assign cnt[gi] = 32'(count);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int s, input int d, input int a, input int t);
    nmq_msg_t m;
    m.header.src          = 2'(s);
    m.header.dst          = 2'(d);
    m.payload.addr_block  = 26'(a);
    m.payload.p_type      = 2'(t);
    return 32'(m);
  endfunction

  function automatic logic [31:0] deq_word(input int unsigned i);
    return {d_src[i], d_dst[i], d_addr[i], d_typ[i]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic        occ;
  logic [31:0] mdata;

  initial begin
    for (int i = 0; i < NQ; i++) begin
      enq_valid[i] = 1'b0;
      deq_ready[i] = 1'b0;
      enq_msg[i]   = '0;
    end
    reset = 1'b1;
    #12;
    for (int i = 0; i < NQ; i++) begin
      check("rst_enq_ready", 32'(enq_ready[i]), 32'd1);
      check("rst_deq_valid", 32'(deq_valid[i]), 32'd0);
      check("rst_count", cnt[i], 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();

    // DEPTH=4 fill then drain
    for (int k = 0; k < 4; k++) begin
      enq_msg[Q4]   = mk(0, 1, k + 1, k);
      enq_valid[Q4] = 1'b1;
      #1;
      check("d4_enq_ready", 32'(enq_ready[Q4]), 32'd1);
      tick();
      check("d4_fill_count", cnt[Q4], 32'(k + 1));
    end
    enq_valid[Q4] = 1'b0;
    #1;
    check("d4_full_enq_ready", 32'(enq_ready[Q4]), 32'd0);
    check("d4_stall_head", deq_word(Q4), mk(0, 1, 1, 0));
    deq_ready[Q4] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("d4_deq_valid", 32'(deq_valid[Q4]), 32'd1);
      check("d4_deq_data", deq_word(Q4), mk(0, 1, k + 1, k));
      tick();
      check("d4_drain_count", cnt[Q4], 32'(3 - k));
    end
    deq_ready[Q4] = 1'b0;
    #1;
    check("d4_empty_valid", 32'(deq_valid[Q4]), 32'd0);

    // DEPTH=3 streaming, pointers wrap several times
    deq_ready[Q3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      enq_msg[Q3]   = mk(k, ~k, 'h10 + k, k + 1);
      enq_valid[Q3] = 1'b1;
      #1;
      check("d3_enq_ready", 32'(enq_ready[Q3]), 32'd1);
      if (k == 0) begin
        check("d3_first_valid", 32'(deq_valid[Q3]), 32'd0);
      end else begin
        check("d3_deq_valid", 32'(deq_valid[Q3]), 32'd1);
        check("d3_deq_data", deq_word(Q3), mk(k - 1, ~(k - 1), 'h10 + k - 1, k));
      end
      tick();
      check("d3_count", cnt[Q3], 32'd1);
    end
    enq_valid[Q3] = 1'b0;
    #1;
    check("d3_last_data", deq_word(Q3), mk(9, ~9, 'h19, 10));
    tick();
    check("d3_final_count", cnt[Q3], 32'd0);
    deq_ready[Q3] = 1'b0;

    // PIPE, DEPTH=2: enqueue while full when dequeue fires
    enq_valid[QP] = 1'b1;
    enq_msg[QP]   = mk(1, 2, 'hA, 1);
    tick();
    enq_msg[QP]   = mk(1, 2, 'hB, 2);
    tick();
    check("pipe_full_count", cnt[QP], 32'd2);
    enq_msg[QP] = mk(1, 2, 'hC, 3);
    #1;
    check("pipe_full_no_ready", 32'(enq_ready[QP]), 32'd0);
    deq_ready[QP] = 1'b1;
    #1;
    check("pipe_full_ready", 32'(enq_ready[QP]), 32'd1);
    check("pipe_head_a", deq_word(QP), mk(1, 2, 'hA, 1));
    tick();
    check("pipe_count_hold1", cnt[QP], 32'd2);
    enq_msg[QP] = mk(1, 2, 'hD, 0);
    #1;
    check("pipe_head_b", deq_word(QP), mk(1, 2, 'hB, 2));
    check("pipe_ready2", 32'(enq_ready[QP]), 32'd1);
    tick();
    check("pipe_count_hold2", cnt[QP], 32'd2);
    enq_valid[QP] = 1'b0;
    #1;
    check("pipe_head_c", deq_word(QP), mk(1, 2, 'hC, 3));
    tick();
    check("pipe_count_1", cnt[QP], 32'd1);
    #1;
    check("pipe_head_d", deq_word(QP), mk(1, 2, 'hD, 0));
    tick();
    check("pipe_count_0", cnt[QP], 32'd0);
    deq_ready[QP] = 1'b0;

    // FLOW, DEPTH=2: zero-latency bypass when empty
    deq_ready[QF] = 1'b1;
    enq_valid[QF] = 1'b1;
    enq_msg[QF]   = mk(0, 0, 'h155, 0);
    #1;
    check("flow_deq_valid", 32'(deq_valid[QF]), 32'd1);
    check("flow_bypass_data", deq_word(QF), mk(0, 0, 'h155, 0));
    check("flow_count_now", cnt[QF], 32'd0);
    tick();
    enq_valid[QF] = 1'b0;
    #1;
    check("flow_count_after", cnt[QF], 32'd0);
    check("flow_idle_valid", 32'(deq_valid[QF]), 32'd0);
    deq_ready[QF] = 1'b0;
    enq_valid[QF] = 1'b1;
    enq_msg[QF]   = mk(3, 1, 'h2A, 2);
    tick();
    enq_valid[QF] = 1'b0;
    check("flow_stored_count", cnt[QF], 32'd1);
    #1;
    check("flow_stored_data", deq_word(QF), mk(3, 1, 'h2A, 2));
    deq_ready[QF] = 1'b1;
    tick();
    check("flow_drained", cnt[QF], 32'd0);
    deq_ready[QF] = 1'b0;

    // DEPTH=1 random stalls against a one-slot model
    occ   = 1'b0;
    mdata = '0;
    for (int c = 0; c < 1000; c++) begin
      enq_valid[Q1] = 1'($urandom_range(0, 1));
      deq_ready[Q1] = 1'($urandom_range(0, 1));
      enq_msg[Q1]   = nmq_msg_t'($urandom);
      #1;
      check("d1_handshake", {30'd0, enq_ready[Q1], deq_valid[Q1]}, {30'd0, ~occ, occ});
      check("d1_count", cnt[Q1], 32'(occ));
      if (occ) check("d1_data", deq_word(Q1), mdata);
      if (occ && deq_ready[Q1]) begin
        occ = 1'b0;
      end else if (!occ && enq_valid[Q1]) begin
        occ   = 1'b1;
        mdata = 32'(enq_msg[Q1]);
      end
      tick();
    end
    enq_valid[Q1] = 1'b0;
    deq_ready[Q1] = 1'b0;

    // DEPTH=4 holding 3, asynchronous reset between edges
    enq_valid[Q4] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      enq_msg[Q4] = mk(2, 3, 'h100 + k, 1);
      tick();
    end
    enq_valid[Q4] = 1'b0;
    check("arst_pre_count", cnt[Q4], 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", cnt[Q4], 32'd0);
    check("arst_deq_valid", 32'(deq_valid[Q4]), 32'd0);
    check("arst_enq_ready", 32'(enq_ready[Q4]), 32'd1);
    #1;
    reset = 1'b0;
    tick();
    check("arst_discard_valid", 32'(deq_valid[Q4]), 32'd0);
    enq_valid[Q4] = 1'b1;
    enq_msg[Q4]   = mk(1, 1, 'h3FF, 3);
    tick();
    enq_valid[Q4] = 1'b0;
    #1;
    check("arst_new_count", cnt[Q4], 32'd1);
    check("arst_new_head", deq_word(Q4), mk(1, 1, 'h3FF, 3));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/network_msg_queue.md
NETWORK_MSG_QUEUE -- requirements
Module: network_msg_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of entries (legal range 1..64; need not be a power of two).
REQ-002 SHALL have parameter ID_W, default 2, width of header src/dst.
REQ-003 SHALL have parameter ADDR_W, default 26, width of payload addr_block.
REQ-004 SHALL have parameter TYPE_W, default 2, width of payload p_type.
REQ-005 SHALL have parameter PIPE, default 0, which allows enqueue while full if dequeue fires in the same cycle.
REQ-006 SHALL have parameter FLOW, default 0, which gives a combinational enq->deq bypass when empty.
REQ-007 SHALL have port clk, input, 1 bit, the single clock.
REQ-008 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-009 SHALL have port io_enq_ready, output, 1 bit, meaning the queue accepts a message.
REQ-010 SHALL have port io_enq_valid, input, 1 bit, meaning the producer offers a message.
REQ-011 SHALL have ports io_enq_bits_header_src and io_enq_bits_header_dst, input, ID_W bits each.
REQ-012 SHALL have ports io_enq_bits_payload_addr_block (ADDR_W bits) and io_enq_bits_payload_p_type (TYPE_W bits), input.
REQ-013 SHALL have port io_deq_ready, input, 1 bit, meaning the consumer accepts.
REQ-014 SHALL have port io_deq_valid, output, 1 bit, meaning the head message is valid.
REQ-015 SHALL have io_deq_bits_* outputs mirroring the four enq fields, with the same widths.
REQ-016 SHALL have port io_count, output, $clog2(DEPTH+1) bits, the occupancy.

Function
REQ-017 do_enq SHALL equal io_enq_ready & io_enq_valid, and do_deq SHALL equal io_deq_ready & io_deq_valid.
REQ-018 Storage SHALL be a circular buffer with enq_ptr, deq_ptr and a maybe_full flag.
REQ-019 Each pointer SHALL increment on its fire, wrapping DEPTH-1 -> 0.
REQ-020 empty SHALL be (enq_ptr==deq_ptr) & ~maybe_full, and full SHALL be (enq_ptr==deq_ptr) & maybe_full.
REQ-021 When do_enq != do_deq, maybe_full SHALL be set to do_enq on the next edge; otherwise it SHALL hold.
REQ-022 The entry at enq_ptr SHALL be written on do_enq, and a data write SHALL never be gated by reset.
REQ-023 Base ready/valid SHALL be io_enq_ready = ~full and io_deq_valid = ~empty.
REQ-024 The head SHALL be read combinationally from the entry at deq_ptr, so an enqueued message appears on deq 1 cycle after enqueue (FLOW=0).
REQ-025 When FLOW=1 and empty: io_deq_valid SHALL equal io_enq_valid and io_deq_bits SHALL equal io_enq_bits.
REQ-026 When FLOW=1, empty and io_deq_ready=1, no write and no pointer movement SHALL occur, giving 0-cycle latency.
REQ-027 When PIPE=1, io_enq_ready SHALL be ~full | io_deq_ready.
REQ-028 When PIPE=1 and full with both sides firing, the write SHALL go to the slot being freed and occupancy SHALL stay DEPTH.
REQ-029 io_count SHALL be (maybe_full & ptr_match) ? DEPTH : (enq_ptr - deq_ptr) mod DEPTH, computed at count width without overflow.
REQ-030 Simultaneous enq and deq when neither empty nor full SHALL leave io_count unchanged.
REQ-031 For DEPTH=1, the pointers SHALL be constant 0 and behaviour SHALL reduce to a single-entry queue driven by maybe_full.
REQ-032 Messages SHALL leave in enqueue order with no loss or duplication.
REQ-033 io_deq_bits SHALL be stable while io_deq_valid=1 and io_deq_ready=0.

Reset
REQ-034 Asserting reset SHALL immediately clear enq_ptr, deq_ptr and maybe_full, independent of clk.
REQ-035 During and after reset, outputs SHALL be: io_enq_ready=1, io_deq_valid=0 (FLOW=1: io_enq_valid), io_count=0.
REQ-036 Reset asserted mid-operation SHALL discard all stored messages.
REQ-037 Storage contents SHALL be left unreset.
REQ-038 Any fire in the cycle reset deasserts SHALL be honoured only from the first clk edge after deassertion.

Structure
REQ-039 A shared package SHALL hold the default widths (ID_W, ADDR_W, TYPE_W) and a typedef of the message struct {header src, dst; payload addr_block, p_type}.
REQ-040 One sub-module, queue_wrap_ptr, SHALL be used: a parametrised modulo-DEPTH counter with increment enable and async reset, instantiated twice.
REQ-041 Everything else SHALL be flat.

Verification
REQ-042 DEPTH=4, FLOW=0, PIPE=0: enqueue addr 0x1,0x2,0x3,0x4 with deq_ready=0 -> count 1..4, enq_ready=0 after the 4th; then deq_ready=1 -> the same 4 values emerge in order over 4 cycles, count 3..0.
REQ-043 DEPTH=3: 10 messages with continuous valid/ready -> one transfer per cycle, count steady at 1, pointers wrap 2->0 without error.
REQ-044 DEPTH=2, PIPE=1, full, both sides firing -> enq_ready=1, count stays 2, order preserved.
REQ-045 DEPTH=2, FLOW=1, empty, enq addr 0x155 with deq_ready=1 -> deq_valid and addr 0x155 in the same cycle, count stays 0.
REQ-046 DEPTH=4 holding 3 entries, reset pulsed between edges -> count=0, deq_valid=0, enq_ready=1 immediately, before the next clk edge.
REQ-047 DEPTH=1 with random stall patterns of 1000 cycles -> behaviour matches a scoreboard model, count never exceeds 1.
